lc3_mem_ctrl: RTL and testbench

- Memory-side responder for the LC-3 MAR/MDR memory interface.
- Accepts one access per request (address from MAR, write data from MDR, direction from R.W) and returns the ready flag R plus read data for MDR.
- Decodes the memory-mapped I/O page into internal keyboard and display registers.
- Sequences all other addresses to an external synchronous SRAM with a fixed number of wait states.

---
 rtl/lc3_mem_pkg.sv | 18 +
 rtl/lc3_mem_ctrl_if.sv | 21 ++
 rtl/lc3_io_regs.sv | 118 +++++++++++
 rtl/lc3_mem_ctrl.sv | 131 +++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory controller.
package lc3_mem_pkg;

    typedef enum logic [1:0] {IDLE, SRAM, DONE} state_e;

    localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;
    localparam logic [15:0] DSR_ADDR_DEF  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR_DEF  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR      = 16'hFFFE;
    localparam logic [15:0] MCR_RESET     = 16'h8000;

    localparam int unsigned KBSR_READY_BIT = 15;
    localparam int unsigned KBSR_IE_BIT    = 14;
    localparam int unsigned DSR_READY_BIT  = 15;
    localparam int unsigned MCR_RUN_BIT    = 15;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// MAR/MDR memory bus between the LC-3 core (master) and the memory controller (slave).
interface lc3_mem_ctrl_if;

    logic        mem_en;
    logic        r_w;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mem_rdata;
    logic        r;

    modport master (
        output mem_en, r_w, mar, mdr_in,
        input  mem_rdata, r
    );

    modport slave (
        input  mem_en, r_w, mar, mdr_in,
        output mem_rdata, r
    );

endinterface

// File: rtl/lc3_io_regs.sv
// Memory-mapped keyboard/display registers (plus MCR when LC3_MCR_EN is defined).
// Accesses take effect on the edge where strobe is high.
module lc3_io_regs
    import lc3_mem_pkg::*;
#(
    parameter logic [15:0] KBSR_ADDR = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR = KBDR_ADDR_DEF,
    parameter logic [15:0] DSR_ADDR  = DSR_ADDR_DEF,
    parameter logic [15:0] DDR_ADDR  = DDR_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        strobe,
    output logic        hit,
    output logic [15:0] rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_irq,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready
`ifdef LC3_MCR_EN
    ,
    output logic        run
`endif
);

    logic       sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
    logic       kb_ready, kb_ie;
    logic [7:0] kbdr;
    logic       unused_wdata;

    assign sel_kbsr = (addr == KBSR_ADDR);
    assign sel_kbdr = (addr == KBDR_ADDR);
    assign sel_dsr  = (addr == DSR_ADDR);
    assign sel_ddr  = (addr == DDR_ADDR);

    assign unused_wdata = ^{wdata[15], wdata[13:8]};
    assign kbd_irq      = kb_ready & kb_ie;

`ifdef LC3_MCR_EN
    logic        sel_mcr;
    logic [15:0] mcr;

    assign sel_mcr = (addr == MCR_ADDR);
    assign hit     = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr | sel_mcr;
    assign run     = mcr[MCR_RUN_BIT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcr <= MCR_RESET;
        end else if (strobe && we && sel_mcr) begin
            mcr <= wdata;
        end
    end
`else
    assign hit = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;
`endif

    always_comb begin
        rdata = '0;
        if (sel_kbsr) begin
            rdata[KBSR_READY_BIT] = kb_ready;
            rdata[KBSR_IE_BIT]    = kb_ie;
        end else if (sel_kbdr) begin
            rdata = {8'h00, kbdr};
        end else if (sel_dsr) begin
            rdata[DSR_READY_BIT] = ~dsp_valid;
        end else if (sel_ddr) begin
            rdata = {8'h00, dsp_data};
        end
`ifdef LC3_MCR_EN
        else if (sel_mcr) begin
            rdata = mcr;
        end
`endif
    end

    // A character strobe in the same cycle as a KBDR read wins: ready stays set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kb_ready <= 1'b0;
            kb_ie    <= 1'b0;
            kbdr     <= 8'h00;
        end else begin
            if (strobe && !we && sel_kbdr) begin
                kb_ready <= 1'b0;
            end
            if (strobe && we && sel_kbsr) begin
                kb_ie <= wdata[KBSR_IE_BIT];
            end
            if (kbd_valid) begin
                kbdr     <= kbd_data;
                kb_ready <= 1'b1;
            end
        end
    end

    // DDR writes are only accepted while the display is idle; otherwise dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsp_valid <= 1'b0;
            dsp_data  <= 8'h00;
        end else begin
            if (dsp_valid && dsp_ready) begin
                dsp_valid <= 1'b0;
            end
            if (strobe && we && sel_ddr && !dsp_valid) begin
                dsp_data  <= wdata[7:0];
                dsp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-side responder: I/O page decode plus wait-stated synchronous SRAM sequencer.
// Optional Machine Control Register and run output enabled by defining LC3_MCR_EN.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] KBSR_ADDR   = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR   = KBDR_ADDR_DEF,
    parameter logic [15:0] DSR_ADDR    = DSR_ADDR_DEF,
    parameter logic [15:0] DDR_ADDR    = DDR_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    lc3_mem_ctrl_if.slave        bus,
    output logic [15:0]          sram_addr,
    output logic [15:0]          sram_wdata,
    input  logic [15:0]          sram_rdata,
    output logic                 sram_ce,
    output logic                 sram_we,
    input  logic                 kbd_valid,
    input  logic [7:0]           kbd_data,
    output logic                 kbd_irq,
    output logic                 dsp_valid,
    output logic [7:0]           dsp_data,
    input  logic                 dsp_ready
`ifdef LC3_MCR_EN
    ,
    output logic                 run
`endif
);

    state_e      state;
    logic [3:0]  cnt;
    logic        r_q;
    logic [15:0] rdata_q;
    logic        io_hit;
    logic        io_strobe;
    logic [15:0] io_rdata;

    assign bus.r         = r_q;
    assign bus.mem_rdata = rdata_q;

    // I/O accesses complete on the accepting edge, so the strobe is decoded from live inputs.
    assign io_strobe = (state == IDLE) && bus.mem_en && io_hit;

    lc3_io_regs #(
        .KBSR_ADDR (KBSR_ADDR),
        .KBDR_ADDR (KBDR_ADDR),
        .DSR_ADDR  (DSR_ADDR),
        .DDR_ADDR  (DDR_ADDR)
    ) u_io_regs (
        .clk       (clk),
        .reset     (reset),
        .addr      (bus.mar),
        .wdata     (bus.mdr_in),
        .we        (bus.r_w),
        .strobe    (io_strobe),
        .hit       (io_hit),
        .rdata     (io_rdata),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .kbd_irq   (kbd_irq),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready)
`ifdef LC3_MCR_EN
        ,
        .run       (run)
`endif
    );

    // sram_we doubles as the latched direction for the duration of an SRAM access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            r_q        <= 1'b0;
            rdata_q    <= 16'h0000;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= 16'h0000;
            sram_wdata <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    r_q <= 1'b0;
                    if (bus.mem_en) begin
                        rdata_q <= 16'h0000;
                        if (io_hit) begin
                            state <= DONE;
                            r_q   <= 1'b1;
                            if (!bus.r_w) begin
                                rdata_q <= io_rdata;
                            end
                        end else begin
                            state      <= SRAM;
                            cnt        <= 4'(WAIT_STATES);
                            sram_ce    <= 1'b1;
                            sram_we    <= bus.r_w;
                            sram_addr  <= bus.mar;
                            sram_wdata <= bus.mdr_in;
                        end
                    end
                end
                SRAM: begin
                    if (cnt == 4'd0) begin
                        if (!sram_we) begin
                            rdata_q <= sram_rdata;
                        end
                        state      <= DONE;
                        r_q        <= 1'b1;
                        sram_ce    <= 1'b0;
                        sram_we    <= 1'b0;
                        sram_addr  <= 16'h0000;
                        sram_wdata <= 16'h0000;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_q   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl; read data checked through a scoreboard on each r pulse.
module tb_lc3_mem_ctrl;

    localparam int unsigned WAIT = 2;
    localparam int          SRAM_LAT = WAIT + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_ce, sram_we;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_irq;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;
`ifdef LC3_MCR_EN
    logic        run;
`endif

    lc3_mem_ctrl_if bus ();

    lc3_mem_ctrl #(
        .WAIT_STATES (WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_irq    (kbd_irq),
        .dsp_valid  (dsp_valid),
        .dsp_data   (dsp_data),
        .dsp_ready  (dsp_ready)
`ifdef LC3_MCR_EN
        ,
        .run        (run)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    int          lat, ce_cycles, we_cycles;
    logic [15:0] addr_seen, wdata_seen;

    // SRAM model: 16 words selected by address[15:12], read data driven mid-cycle.
    logic [15:0] sram_mem [16];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= 16'h0000;
            sram_mem[3]  <= 16'h1234;
            sram_mem[15] <= 16'hA5A5;
        end else if (sram_ce && sram_we) begin
            sram_mem[sram_addr[15:12]] <= sram_wdata;
        end
    end

    always @(negedge clk) sram_rdata = sram_mem[sram_addr[15:12]];

    // Scoreboard consumer.
    always @(posedge clk) begin
        logic [15:0] exp;
        #1;
        if (bus.r === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_r: r pulsed with no access outstanding, mem_rdata=%h",
                         bus.mem_rdata);
            end else begin
                exp = sb.pop_front();
                if (bus.mem_rdata !== exp) begin
                    errors++;
                    $display("FAIL mem_rdata: got %h expected %h", bus.mem_rdata, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at a negedge with lat/ce/we statistics filled in.
    task automatic do_access(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                             input logic [15:0] exp);
        sb.push_back(exp);
        bus.mem_en = 1'b1;
        bus.r_w    = rw;
        bus.mar    = addr;
        bus.mdr_in = data;
        ce_cycles = 0; we_cycles = 0; addr_seen = 16'h0; wdata_seen = 16'h0;
        @(posedge clk);
        lat = 1;
        #1;
        while (bus.r !== 1'b1 && lat < 40) begin
            if (sram_ce === 1'b1) begin
                ce_cycles++;
                if (sram_we === 1'b1) we_cycles++;
                addr_seen  = sram_addr;
                wdata_seen = sram_wdata;
            end
            @(posedge clk);
            lat++;
            #1;
        end
        bus.mem_en = 1'b0;
        if (bus.r !== 1'b1) begin
            checks++; errors++;
            $display("FAIL r_timeout: no r after %0d cycles for addr %h", lat, addr);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.r !== 1'b0) begin
            errors++;
            $display("FAIL r_width: r=%b one cycle after pulse, expected 0", bus.r);
        end
        @(negedge clk);
    endtask

    task automatic kbd_pulse(input logic [7:0] ch);
        kbd_valid = 1'b1;
        kbd_data  = ch;
        @(negedge clk);
        kbd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_en = 1'b0; bus.r_w = 1'b0; bus.mar = 16'h0; bus.mdr_in = 16'h0;
        kbd_valid = 1'b0; kbd_data = 8'h00; dsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.r, bus.mem_rdata, sram_ce, sram_we, sram_addr, sram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: r=%b rdata=%h ce=%b we=%b addr=%h wdata=%h, expected all 0",
                     bus.r, bus.mem_rdata, sram_ce, sram_we, sram_addr, sram_wdata);
        end
        checks++;
        if ({kbd_irq, dsp_valid, dsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_io: irq=%b dsp_valid=%b dsp_data=%h, expected 0",
                     kbd_irq, dsp_valid, dsp_data);
        end
`ifdef LC3_MCR_EN
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL reset_run: run=%b expected 1", run);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sram_read();
        do_access(1'b0, 16'h3000, 16'h0000, 16'h1234);
        checks++;
        if (lat != SRAM_LAT || ce_cycles != WAIT + 1 || we_cycles != 0 || addr_seen !== 16'h3000)
        begin
            errors++;
            $display("FAIL sram_read_seq: lat=%0d ce=%0d we=%0d addr=%h expected %0d %0d 0 3000",
                     lat, ce_cycles, we_cycles, addr_seen, SRAM_LAT, WAIT + 1);
        end
    endtask

    task automatic test_sram_write();
        do_access(1'b1, 16'h4000, 16'hBEEF, 16'h0000);
        checks++;
        if (lat != SRAM_LAT || ce_cycles != WAIT + 1 || we_cycles != WAIT + 1 ||
            addr_seen !== 16'h4000 || wdata_seen !== 16'hBEEF) begin
            errors++;
            $display("FAIL sram_write_seq: lat=%0d ce=%0d we=%0d addr=%h data=%h expected %0d %0d %0d 4000 BEEF",
                     lat, ce_cycles, we_cycles, addr_seen, wdata_seen, SRAM_LAT, WAIT + 1, WAIT + 1);
        end
        do_access(1'b0, 16'h4000, 16'h0000, 16'hBEEF);
    endtask

    task automatic test_keyboard();
        kbd_pulse(8'h41);
        checks++;
        if (kbd_irq !== 1'b0) begin
            errors++; $display("FAIL kbd_irq_masked: got %b expected 0", kbd_irq);
        end
        do_access(1'b0, 16'hFE00, 16'h0000, 16'h8000);
        checks++;
        if (lat != 1 || ce_cycles != 0) begin
            errors++; $display("FAIL io_latency: lat=%0d ce=%0d expected 1 0", lat, ce_cycles);
        end
        do_access(1'b0, 16'hFE02, 16'h0000, 16'h0041);
        do_access(1'b0, 16'hFE00, 16'h0000, 16'h0000);
        do_access(1'b1, 16'hFE00, 16'h4000, 16'h0000);
        kbd_pulse(8'h42);
        checks++;
        if (kbd_irq !== 1'b1) begin
            errors++; $display("FAIL kbd_irq_set: got %b expected 1", kbd_irq);
        end
        do_access(1'b0, 16'hFE00, 16'h0000, 16'hC000);
        kbd_pulse(8'h43);
        do_access(1'b0, 16'hFE02, 16'h0000, 16'h0043);
        checks++;
        if (kbd_irq !== 1'b0) begin
            errors++; $display("FAIL kbd_irq_clear: got %b expected 0", kbd_irq);
        end
        // New character on the same edge as a KBDR read: old value returned, ready kept.
        kbd_valid = 1'b1;
        kbd_data  = 8'h44;
        fork
            begin
                @(posedge clk);
                #1 kbd_valid = 1'b0;
            end
        join_none
        do_access(1'b0, 16'hFE02, 16'h0000, 16'h0043);
        do_access(1'b0, 16'hFE00, 16'h0000, 16'hC000);
        do_access(1'b1, 16'hFE02, 16'h00FF, 16'h0000);
        do_access(1'b0, 16'hFE02, 16'h0000, 16'h0044);
    endtask

    task automatic test_display();
        do_access(1'b1, 16'hFE06, 16'h0058, 16'h0000);
        checks++;
        if (dsp_valid !== 1'b1 || dsp_data !== 8'h58) begin
            errors++;
            $display("FAIL ddr_load: valid=%b data=%h expected 1 58", dsp_valid, dsp_data);
        end
        do_access(1'b0, 16'hFE04, 16'h0000, 16'h0000);
        do_access(1'b1, 16'hFE06, 16'h0059, 16'h0000);
        checks++;
        if (dsp_valid !== 1'b1 || dsp_data !== 8'h58) begin
            errors++;
            $display("FAIL ddr_drop: valid=%b data=%h expected 1 58", dsp_valid, dsp_data);
        end
        do_access(1'b0, 16'hFE06, 16'h0000, 16'h0058);
        dsp_ready = 1'b1;
        @(negedge clk);
        dsp_ready = 1'b0;
        checks++;
        if (dsp_valid !== 1'b0) begin
            errors++; $display("FAIL dsp_handshake: valid=%b expected 0", dsp_valid);
        end
        do_access(1'b0, 16'hFE04, 16'h0000, 16'h8000);
    endtask

    task automatic test_abort();
        int r_seen = 0;
        kbd_pulse(8'h55);
        do_access(1'b1, 16'hFE06, 16'h0021, 16'h0000);
        bus.mem_en = 1'b1; bus.r_w = 1'b0; bus.mar = 16'h3000;
        @(posedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (sram_ce !== 1'b1) begin
            errors++; $display("FAIL abort_pre: sram_ce=%b expected 1", sram_ce);
        end
        reset = 1'b1;
        bus.mem_en = 1'b0;
        #1;
        checks++;
        if ({sram_ce, sram_we, sram_addr, kbd_irq, dsp_valid, dsp_data, bus.r} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: ce=%b we=%b addr=%h irq=%b dv=%b dd=%h r=%b expected 0",
                     sram_ce, sram_we, sram_addr, kbd_irq, dsp_valid, dsp_data, bus.r);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.r === 1'b1) r_seen++;
        end
        checks++;
        if (r_seen != 0) begin
            errors++; $display("FAIL abort_no_r: r pulses=%0d expected 0", r_seen);
        end
        @(negedge clk);
        do_access(1'b0, 16'h3000, 16'h0000, 16'h1234);
        checks++;
        if (lat != SRAM_LAT) begin
            errors++; $display("FAIL abort_recover: lat=%0d expected %0d", lat, SRAM_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] r_trace;
        sb.push_back(16'h0000);
        sb.push_back(16'h0000);
        bus.mem_en = 1'b1; bus.r_w = 1'b0; bus.mar = 16'hFE00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            r_trace[i] = bus.r;
            if (i == 2) bus.mem_en = 1'b0;
        end
        checks++;
        if (r_trace !== 4'b0101) begin
            errors++; $display("FAIL back_to_back: r trace=%b expected 0101", r_trace);
        end
        @(negedge clk);
    endtask

`ifdef LC3_MCR_EN
    task automatic test_mcr();
        do_access(1'b0, 16'hFFFE, 16'h0000, 16'h8000);
        checks++;
        if (lat != 1 || run !== 1'b1) begin
            errors++; $display("FAIL mcr_read: lat=%0d run=%b expected 1 1", lat, run);
        end
        sb.push_back(16'h0000);
        bus.mem_en = 1'b1; bus.r_w = 1'b1; bus.mar = 16'hFFFE; bus.mdr_in = 16'h0000;
        @(posedge clk);
        #1;
        bus.mem_en = 1'b0;
        checks++;
        if (run !== 1'b0 || bus.r !== 1'b1) begin
            errors++; $display("FAIL mcr_halt: run=%b r=%b expected 0 1", run, bus.r);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_mcr();
        do_access(1'b0, 16'hFFFE, 16'h0000, 16'hA5A5);
        checks++;
        if (lat != SRAM_LAT || ce_cycles != WAIT + 1) begin
            errors++;
            $display("FAIL fffe_is_sram: lat=%0d ce=%0d expected %0d %0d",
                     lat, ce_cycles, SRAM_LAT, WAIT + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sram_read();
        test_sram_write();
        test_keyboard();
        test_display();
        test_abort();
        test_back_to_back();
        test_mcr();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
